// File: rtl/bram_sp_arb2_pkg.sv
// Shared definitions for the two-requester single-port RAM arbiter.
//   ADDR_W_DEF / DATA_W_DEF : default address and data widths
//   REQ0 / REQ1             : requester index encodings (also the last_gnt values)
//   cmd_t                   : one RAM command {we, addr, wdata} at default widths
package bram_sp_arb2_pkg;

  localparam int ADDR_W_DEF = 10;
  localparam int DATA_W_DEF = 16;

  localparam logic REQ0 = 1'b0;
  localparam logic REQ1 = 1'b1;

  typedef struct packed {
    logic                  we;
    logic [ADDR_W_DEF-1:0] addr;
    logic [DATA_W_DEF-1:0] wdata;
  } cmd_t;

endpackage

// File: rtl/bram_sp_arb2_spram_core.sv
// Plain single-port RAM with a registered read port.
//   clk_i  : clock
//   en_i   : access enable for this edge
//   we_i   : 1 = write di_i to addr_i, 0 = read addr_i into dout_o
//   addr_i : word address
//   di_i   : write data
//   dout_o : read data, valid the cycle after a read; holds otherwise.
//            Not reset, so it maps onto a block-RAM output register.
module spram_core
  import bram_sp_arb2_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk_i,
  input  logic              en_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] di_i,
  output logic [DATA_W-1:0] dout_o
);

  logic [DATA_W-1:0] mem_q [0:(1<<ADDR_W)-1];

  always_ff @(posedge clk_i) begin
    if (en_i) begin
      if (we_i) begin
        mem_q[addr_i] <= di_i;
      end else begin
        dout_o <= mem_q[addr_i];
      end
    end
  end

endmodule

// File: rtl/bram_sp_arb2.sv
// Two-requester round-robin arbiter in front of one single-port RAM.
//   clk, rst                      : clock, synchronous active-high reset
//   reqN_valid/ready/we/addr/wdata: command channel of requester N (N = 0, 1)
//   rsp0_valid, rsp1_valid        : one-cycle read-response strobes, tagged per requester
//   rsp_rdata                     : shared read-data bus; holds its last value when idle
//
// Handshake: a command transfers on a rising edge where reqN_valid and
// reqN_ready are both 1. ready is a same-cycle combinational grant, never
// asserts without valid, and is forced low while rst is high. The requester
// must keep valid asserted until it sees ready; the command fields sampled
// are whatever is presented in the accepting cycle.
module bram_sp_arb2
  import bram_sp_arb2_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic              req0_we,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_wdata,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic              req1_we,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_wdata,
  output logic              rsp0_valid,
  output logic              rsp1_valid,
  output logic [DATA_W-1:0] rsp_rdata
);

  // Same layout as cmd_t, sized by this instance's parameters.
  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } port_cmd_t;

  logic              last_gnt_q, last_gnt_d;
  logic              rsp0_q, rsp0_d;
  logic              rsp1_q, rsp1_d;
  logic [DATA_W-1:0] hold_q, hold_d;
  logic              gnt0, gnt1, accept, rsp_any;
  port_cmd_t         sel_cmd;
  logic [DATA_W-1:0] ram_dout;

  always_comb begin
    // Requester 0 wins unless requester 1 is also asking and 0 went last.
    gnt0 = req0_valid && (!req1_valid || (last_gnt_q == REQ1));
    gnt1 = req1_valid && !gnt0;

    req0_ready = gnt0 && !rst;
    req1_ready = gnt1 && !rst;
    accept     = req0_ready || req1_ready;

    if (gnt1) begin
      sel_cmd = '{we: req1_we, addr: req1_addr, wdata: req1_wdata};
    end else begin
      sel_cmd = '{we: req0_we, addr: req0_addr, wdata: req0_wdata};
    end

    last_gnt_d = last_gnt_q;
    if (accept) begin
      last_gnt_d = gnt1 ? REQ1 : REQ0;
    end

    rsp0_d  = req0_ready && !req0_we;
    rsp1_d  = req1_ready && !req1_we;
    rsp_any = rsp0_q || rsp1_q;

    // The RAM output register has no reset, so a resettable shadow copy
    // supplies the reset value and the "hold when idle" value.
    hold_d    = rsp_any ? ram_dout : hold_q;
    rsp_rdata = rsp_any ? ram_dout : hold_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_gnt_q <= REQ1;
      rsp0_q     <= 1'b0;
      rsp1_q     <= 1'b0;
      hold_q     <= '0;
    end else begin
      last_gnt_q <= last_gnt_d;
      rsp0_q     <= rsp0_d;
      rsp1_q     <= rsp1_d;
      hold_q     <= hold_d;
    end
  end

  assign rsp0_valid = rsp0_q;
  assign rsp1_valid = rsp1_q;

  spram_core #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_ram (
    .clk_i  (clk),
    .en_i   (accept),
    .we_i   (sel_cmd.we),
    .addr_i (sel_cmd.addr),
    .di_i   (sel_cmd.wdata),
    .dout_o (ram_dout)
  );

endmodule

// File: tb/tb_bram_sp_arb2.sv
module tb_bram_sp_arb2;
  import bram_sp_arb2_pkg::*;

  localparam int AW = ADDR_W_DEF;
  localparam int DW = DATA_W_DEF;

  // ---------------- clock / reset / DUT ----------------
  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req0_valid = 1'b0, req0_we = 1'b0;
  logic [AW-1:0] req0_addr = '0;
  logic [DW-1:0] req0_wdata = '0;
  logic          req1_valid = 1'b0, req1_we = 1'b0;
  logic [AW-1:0] req1_addr = '0;
  logic [DW-1:0] req1_wdata = '0;
  logic          req0_ready, req1_ready, rsp0_valid, rsp1_valid;
  logic [DW-1:0] rsp_rdata;

  always #5 clk = ~clk;

  bram_sp_arb2 #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk        (clk),
    .rst        (rst),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_we    (req0_we),
    .req0_addr  (req0_addr),
    .req0_wdata (req0_wdata),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_we    (req1_we),
    .req1_addr  (req1_addr),
    .req1_wdata (req1_wdata),
    .rsp0_valid (rsp0_valid),
    .rsp1_valid (rsp1_valid),
    .rsp_rdata  (rsp_rdata)
  );

  // ---------------- scoreboard state ----------------
  int            checks = 0;
  int            errors = 0;
  logic [DW-1:0] exp_q[$];

  task automatic check(input string name, input int idx,
                       input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s row %0d: got %0h expected %0h", name, idx, act, exp);
    end
  endtask

  // ---------------- stimulus helpers ----------------
  function automatic cmd_t rd(input logic [AW-1:0] a);
    return '{we: 1'b0, addr: a, wdata: '0};
  endfunction

  function automatic cmd_t wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
    return '{we: 1'b1, addr: a, wdata: d};
  endfunction

  task automatic drive(input logic r, input logic v0, input cmd_t c0,
                       input logic v1, input cmd_t c1);
    rst        = r;
    req0_valid = v0;
    req0_we    = c0.we;
    req0_addr  = c0.addr;
    req0_wdata = c0.wdata;
    req1_valid = v1;
    req1_we    = c1.we;
    req1_addr  = c1.addr;
    req1_wdata = c1.wdata;
  endtask

  // One row = one clock cycle: inputs for the cycle and the outputs
  // expected in that same cycle (ready from these inputs, rsp from the
  // acceptance at the previous edge).
  typedef struct {
    logic          rst;
    logic          v0;
    cmd_t          c0;
    logic          v1;
    cmd_t          c1;
    logic          r0;
    logic          r1;
    logic          s0;
    logic          s1;
    logic [DW-1:0] rdata;
  } vec_t;

  localparam int NV = 30;
  vec_t vecs[NV];

  function automatic vec_t mk(input logic r, input logic v0, input cmd_t c0,
                              input logic v1, input cmd_t c1,
                              input logic r0, input logic r1,
                              input logic s0, input logic s1,
                              input logic [DW-1:0] rdata);
    vec_t v;
    v.rst = r; v.v0 = v0; v.c0 = c0; v.v1 = v1; v.c1 = c1;
    v.r0 = r0; v.r1 = r1; v.s0 = s0; v.s1 = s1; v.rdata = rdata;
    return v;
  endfunction

  initial begin
    cmd_t nop;
    nop = rd(10'h000);

    //            rst v0 c0                      v1 c1                 r0 r1 s0 s1 rdata
    // write then read back on requester 0
    vecs[0]  = mk(0, 1, wr(10'h005, 16'hBEEF), 0, nop,                 1, 0, 0, 0, 16'h0000);
    vecs[1]  = mk(0, 1, rd(10'h005),           0, nop,                 1, 0, 0, 0, 16'h0000);
    vecs[2]  = mk(0, 0, nop,                   0, nop,                 0, 0, 1, 0, 16'hBEEF);
    // preload for the fairness run
    vecs[3]  = mk(0, 1, wr(10'h010, 16'h1111), 0, nop,                 1, 0, 0, 0, 16'hBEEF);
    vecs[4]  = mk(0, 0, nop,                   1, wr(10'h020, 16'h2222), 0, 1, 0, 0, 16'hBEEF);
    vecs[5]  = mk(1, 0, nop,                   0, nop,                 0, 0, 0, 0, 16'hBEEF);
    // both valid for six cycles: 0,1,0,1,0,1
    vecs[6]  = mk(0, 1, rd(10'h010),           1, rd(10'h020),         1, 0, 0, 0, 16'h0000);
    vecs[7]  = mk(0, 1, rd(10'h010),           1, rd(10'h020),         0, 1, 1, 0, 16'h1111);
    vecs[8]  = mk(0, 1, rd(10'h010),           1, rd(10'h020),         1, 0, 0, 1, 16'h2222);
    vecs[9]  = mk(0, 1, rd(10'h010),           1, rd(10'h020),         0, 1, 1, 0, 16'h1111);
    vecs[10] = mk(0, 1, rd(10'h010),           1, rd(10'h020),         1, 0, 0, 1, 16'h2222);
    vecs[11] = mk(0, 1, rd(10'h010),           1, rd(10'h020),         0, 1, 1, 0, 16'h1111);
    vecs[12] = mk(0, 0, nop,                   0, nop,                 0, 0, 0, 1, 16'h2222);
    // same-cycle write/read contention at top address
    vecs[13] = mk(0, 1, wr(10'h3FF, 16'hA5A5), 1, rd(10'h3FF),         1, 0, 0, 0, 16'h2222);
    vecs[14] = mk(0, 0, nop,                   1, rd(10'h3FF),         0, 1, 0, 0, 16'h2222);
    vecs[15] = mk(0, 0, nop,                   0, nop,                 0, 0, 0, 1, 16'hA5A5);
    vecs[16] = mk(0, 0, nop,                   0, nop,                 0, 0, 0, 0, 16'hA5A5);
    vecs[17] = mk(0, 0, nop,                   0, nop,                 0, 0, 0, 0, 16'hA5A5);
    vecs[18] = mk(0, 0, nop,                   0, nop,                 0, 0, 0, 0, 16'hA5A5);
    // req0 goes last, then idle gap; pointer must survive the gap
    vecs[19] = mk(0, 1, rd(10'h005),           0, nop,                 1, 0, 0, 0, 16'hA5A5);
    vecs[20] = mk(0, 0, nop,                   0, nop,                 0, 0, 1, 0, 16'hBEEF);
    vecs[21] = mk(0, 0, nop,                   0, nop,                 0, 0, 0, 0, 16'hBEEF);
    vecs[22] = mk(0, 0, nop,                   0, nop,                 0, 0, 0, 0, 16'hBEEF);
    vecs[23] = mk(0, 1, rd(10'h005),           1, rd(10'h010),         0, 1, 0, 0, 16'hBEEF);
    vecs[24] = mk(0, 0, nop,                   0, nop,                 0, 0, 0, 1, 16'h1111);
    // one-cycle reset during a continuous req0 read stream
    vecs[25] = mk(0, 1, rd(10'h005),           0, nop,                 1, 0, 0, 0, 16'h1111);
    vecs[26] = mk(1, 1, rd(10'h005),           0, nop,                 0, 0, 1, 0, 16'hBEEF);
    vecs[27] = mk(0, 1, rd(10'h005),           1, rd(10'h010),         1, 0, 0, 0, 16'h0000);
    vecs[28] = mk(0, 0, nop,                   1, rd(10'h010),         0, 1, 1, 0, 16'hBEEF);
    vecs[29] = mk(0, 0, nop,                   0, nop,                 0, 0, 0, 1, 16'h1111);
  end

  // ---------------- test sequence ----------------
  initial begin
    // reset held for two edges with a request pending
    drive(1, 1, rd(10'h000), 1, rd(10'h001));
    @(negedge clk);
    @(negedge clk);
    #1;
    check("reset_ready0", -1, 32'(req0_ready), 32'h0);
    check("reset_ready1", -1, 32'(req1_ready), 32'h0);
    check("reset_rsp0",   -1, 32'(rsp0_valid), 32'h0);
    check("reset_rsp1",   -1, 32'(rsp1_valid), 32'h0);
    check("reset_rdata",  -1, 32'(rsp_rdata),  32'h0);

    // table-driven vectors
    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      drive(vecs[i].rst, vecs[i].v0, vecs[i].c0, vecs[i].v1, vecs[i].c1);
      #1;
      check("ready0", i, 32'(req0_ready), 32'(vecs[i].r0));
      check("ready1", i, 32'(req1_ready), 32'(vecs[i].r1));
      check("rsp0",   i, 32'(rsp0_valid), 32'(vecs[i].s0));
      check("rsp1",   i, 32'(rsp1_valid), 32'(vecs[i].s1));
      check("rdata",  i, 32'(rsp_rdata),  32'(vecs[i].rdata));
    end

    // preload 0..7 through requester 0
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      drive(0, 1, wr(AW'(i), DW'(16'hC000 + i)), 0, rd(10'h000));
      #1;
      check("fill_ready0", i, 32'(req0_ready), 32'h1);
      check("fill_rsp1",   i, 32'(rsp1_valid), 32'h0);
    end

    // requester 1 streams reads 0..7; one response per cycle, in order
    for (int c = 0; c <= 8; c++) begin
      @(negedge clk);
      if (c < 8) begin
        drive(0, 0, rd(10'h000), 1, rd(AW'(c)));
        exp_q.push_back(DW'(16'hC000 + c));
      end else begin
        drive(0, 0, rd(10'h000), 0, rd(10'h000));
      end
      #1;
      if (c < 8) check("stream_ready1", c, 32'(req1_ready), 32'h1);
      check("stream_rsp0", c, 32'(rsp0_valid), 32'h0);
      if (c > 0) begin
        check("stream_rsp1", c, 32'(rsp1_valid), 32'h1);
        if (exp_q.size() > 0) begin
          check("stream_rdata", c, 32'(rsp_rdata), 32'(exp_q.pop_front()));
        end
      end
    end
    @(negedge clk);
    #1;
    check("stream_end_rsp1", 9, 32'(rsp1_valid), 32'h0);
    check("stream_end_hold", 9, 32'(rsp_rdata),  32'hC007);
    check("stream_queue_empty", 9, 32'(exp_q.size()), 32'h0);

    // ---------------- report ----------------
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bram_sp_arb2.md
Name: bram_sp_arb2

Overview:
Two-requester round-robin arbiter wrapped around a single-port block RAM.
- Each requester issues read or write commands through a valid/ready handshake.
- The arbiter grants at most one access per cycle to the single RAM port.
- Read data returns one cycle after acceptance, tagged to the requester that issued it.
- Sits between two independent masters (e.g. a producer and a consumer engine) and the shared on-chip buffer.

Parameters:
ADDR_W, 10, address width; RAM depth is 2**ADDR_W words
DATA_W, 16, data word width

Ports:
clk  in  1  single clock; all logic on rising edge
rst  in  1  synchronous, active-high reset
req0_valid  in  1  requester 0 command valid
req0_ready  out  1  requester 0 command accepted this cycle
req0_we  in  1  1 = write, 0 = read
req0_addr  in  ADDR_W  word address
req0_wdata  in  DATA_W  write data
req1_valid / req1_ready / req1_we / req1_addr / req1_wdata  same as above, requester 1
rsp0_valid  out  1  read data for requester 0 valid on rsp_rdata
rsp1_valid  out  1  read data for requester 1 valid on rsp_rdata
rsp_rdata  out  DATA_W  shared read-data bus

Behaviour:
- Reset state:
  - rsp0_valid = rsp1_valid = 0; rsp_rdata = 0.
  - Round-robin pointer last_gnt = 1, so requester 0 wins the first contention.
  - RAM contents are not cleared.
- While rst = 1:
  - req0_ready = req1_ready = 0; no RAM access occurs.
  - Outputs are forced to their reset values at the next edge.
  - A read accepted in the cycle before rst rises still returns its response in the cycle rst is high (rsp registered at that edge); rst then clears it the following edge.
- Grant (combinational, same cycle):
  - Only req0_valid = 1: grant 0.
  - Only req1_valid = 1: grant 1.
  - Both valid: grant the requester that is not last_gnt.
  - reqN_ready = granted AND NOT rst; ready never asserts without valid.
  - last_gnt updates to the granted index at the edge where an access is accepted; it is unchanged on idle cycles.
- Access: the accepted command drives the RAM port at that edge (en = 1, we = req_we, addr, wdata).
- Read latency is 1:
  - rspN_valid = 1 for exactly one cycle, the cycle after a read from requester N was accepted.
  - rsp_rdata carries the RAM word in that cycle.
  - rsp_rdata holds its last value when no response is pending.
  - At most one of rsp0_valid / rsp1_valid is high in any cycle.
- Writes produce no response. Write data is visible to any read accepted in a later cycle.
- Back-to-back: a requester holding valid continuously with the other idle is accepted every cycle, at full throughput.
- Fairness: with both requesters continuously valid, grants alternate 0, 1, 0, 1…; neither waits more than one cycle.
- Requesters must hold command fields stable while valid = 1 and ready = 0. A change while waiting is not an error; the arbiter uses the current values at acceptance.
- Address width is exact: every address in 0 … 2**ADDR_W−1 is legal; there is no wrap or bounds check.

Decomposition:
- Shared package holds:
  - default ADDR_W / DATA_W constants;
  - requester index constants REQ0 = 0, REQ1 = 1;
  - a command struct/typedef {we, addr, wdata} reused by future multi-port variants.
- One sub-module, spram_core: a plain single-port RAM with en, we, addr, di and a registered dout, no reset on dout.
- Arbiter, grant pointer and response tag register live in bram_sp_arb2.

Test Plan:
- Reset, then req0 write addr 0x005 data 0xBEEF; next cycle req0 read 0x005 -> req0_ready = 1 both cycles; rsp0_valid = 1 one cycle later with rsp_rdata = 0xBEEF; rsp1_valid stays 0.
- Both valid continuously for 6 cycles after reset, both reading pre-written addresses 0x010 = 0x1111 and 0x020 = 0x2222 -> grant order 0, 1, 0, 1, 0, 1; responses alternate rsp0 0x1111 / rsp1 0x2222, each one cycle after its grant.
- Same-cycle contention: req0 write 0x3FF = 0xA5A5 and req1 read 0x3FF, with last_gnt = 1 -> req0 granted first; req1 granted the next cycle and receives 0xA5A5.
- Single requester streaming: req1 reads 0x000 … 0x007 back-to-back -> ready high every cycle; eight consecutive rsp1_valid pulses in address order.
- rst asserted for 1 cycle while req0 is continuously valid reading 0x005 -> req0_ready = 0 during rst; rsp0_valid = 0 the cycle after rst; first post-reset contention is won by req0; RAM still holds 0xBEEF at 0x005.
- Idle gaps: no valid for 3 cycles -> no ready, no rsp_valid; rsp_rdata holds its previous value; last_gnt unchanged.
